homing_sequencer: RTL and testbench
===================================

HOMING_SEQUENCER -- requirements
Module: homing_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000; clk cycles per ramp/timeout tick (1 kHz at 100 MHz).
REQ-002 Parameter VEL_W, default 32; width of velocity and position words.
REQ-003 clk  in  1  100 MHz system clock; the only clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse; begin a homing run.
REQ-006 abort  in  1  single-cycle pulse; ramp to zero and end the run without completion.
REQ-007 encoder_index  in  1  raw encoder Index signal, asynchronous to clk.
REQ-008 actual_position  in  VEL_W signed  quadrature encoder position count.
REQ-009 homing_vel  in  VEL_W signed  seek velocity; its sign sets the direction.
REQ-010 accel_step  in  16 unsigned  velocity change per tick.
REQ-011 timeout_ms  in  16 unsigned  tick budget for RAMP_UP+SEEK; 0 disables the timeout.
REQ-012 desired_vel  out  VEL_W signed  velocity command to the PI velocity controller.
REQ-013 home_offset  out  VEL_W signed  actual_position latched at the Index edge.
REQ-014 busy / done / fault  out  1 each  run active / run completed / run failed.
REQ-015 fault_code  out  2  00 none, 01 timeout, 10 zero homing_vel.
REQ-016 state  out  3  current FSM state encoding, for debug.

Function
REQ-017 The tick prescaler SHALL free-run from reset over 0..TICK_DIV-1 and assert tick for one cycle at wrap.
REQ-018 encoder_index SHALL pass a 2-flop synchronizer plus a rising-edge detector; idx_rise is asserted 3 clk cycles after the input rises.
REQ-019 States SHALL be IDLE(0), RAMP_UP(1), SEEK(2), RAMP_DOWN(3), DONE(4), FAULT(5).
REQ-020 IDLE/DONE/FAULT on start (abort low): latch homing_vel, accel_step and timeout_ms; clear done, fault, fault_code and the tick counter; enter RAMP_UP.
REQ-021 If the latched homing_vel is 0, the FSM SHALL enter FAULT on the next cycle with fault_code=10.
REQ-022 RAMP_UP: on each tick, desired_vel SHALL move toward the target by step; reaching the target enters SEEK on the same tick.
REQ-023 Ramp arithmetic: difference computed at VEL_W+1 bits; if |diff| <= step, desired_vel = target, else desired_vel = desired_vel ± step; step = accel_step zero-extended, with 0 treated as 1.
REQ-024 idx_rise in RAMP_UP or SEEK SHALL latch actual_position into home_offset in that cycle and enter RAMP_DOWN; idx_rise in any other state is ignored.
REQ-025 The timeout counter SHALL increment per tick in RAMP_UP and SEEK; when it equals timeout_ms (nonzero), enter FAULT with fault_code=01.
REQ-026 If idx_rise and the timeout occur in the same cycle, the index wins.
REQ-027 RAMP_DOWN: on each tick, desired_vel SHALL ramp toward 0; at 0, enter DONE (done=1), or enter IDLE if the run was aborted.
REQ-028 abort in RAMP_UP or SEEK SHALL set the aborted flag and enter RAMP_DOWN; abort in RAMP_DOWN sets the flag only; abort in idle states is a no-op and beats a simultaneous start.
REQ-029 On entry to FAULT, desired_vel SHALL be forced to 0 in the same cycle, with no ramp.
REQ-030 start while busy SHALL be ignored.
REQ-031 busy=1 exactly in RAMP_UP, SEEK and RAMP_DOWN; done and fault hold until the next accepted start.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 Reset SHALL set: state=IDLE, desired_vel=0, home_offset=0, busy=0, done=0, fault=0, fault_code=00, prescaler=0, timeout counter=0, synchronizer flops=0, aborted=0.
REQ-034 Reset asserted mid-run SHALL zero desired_vel immediately (asynchronously).

Structure
REQ-035 Package motor_ctrl_pkg SHALL hold the state encoding, the fault_code constants and the default TICK_DIV.
REQ-036 One sub-module, vel_ramp, SHALL implement REQ-023 (current, target, step -> next, at_target); it is combinational and registered by the parent.

Verification (TICK_DIV=10)
REQ-037 homing_vel=1000, accel_step=250, index after 10 ticks -> desired_vel 250/500/750/1000, SEEK, home_offset=actual_position at the edge, ramps down, done=1, desired_vel=0.
REQ-038 timeout_ms=5, no index -> FAULT after 5 ticks, fault_code=01, desired_vel=0 in the same cycle.
REQ-039 homing_vel=-300, accel_step=0 -> desired_vel decrements by 1 per tick down to -300.
REQ-040 abort during SEEK at 1000, accel_step=500 -> 500, then 0, then IDLE, done=0, fault=0.
REQ-041 homing_vel=0 -> FAULT, fault_code=10; start and abort in the same cycle in IDLE -> state stays IDLE.
REQ-042 reset_n low mid-RAMP_UP -> all outputs at reset values without waiting for a clk edge.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the homing sequencer: FSM state encoding, fault codes
// and the default tick prescaler divisor.
package motor_ctrl_pkg;

    localparam int TICK_DIV_DEFAULT = 100000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_SEEK      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAULT     = 3'd5
    } hs_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_ZERO_VEL = 2'b10;

    function automatic logic is_busy(input hs_state_e s);
        return (s == ST_RAMP_UP) || (s == ST_SEEK) || (s == ST_RAMP_DOWN);
    endfunction

    // States in which the index is watched and the timeout runs.
    function automatic logic is_seeking(input hs_state_e s);
        return (s == ST_RAMP_UP) || (s == ST_SEEK);
    endfunction

endpackage

// File: rtl/vel_ramp.sv
// Combinational velocity ramp step: moves current toward target by step,
// snapping onto the target when it is within one step.
module vel_ramp #(
    parameter int VEL_W = 32
) (
    input  logic signed [VEL_W-1:0] current,
    input  logic signed [VEL_W-1:0] target,
    input  logic        [15:0]      step,
    output logic signed [VEL_W-1:0] next,
    output logic                    at_target
);

    logic signed [VEL_W:0] cur_ext;
    logic signed [VEL_W:0] diff;
    logic signed [VEL_W:0] moved;
    logic        [VEL_W:0] diff_mag;
    logic        [VEL_W:0] step_ext;

    // One extra bit keeps target - current exact across the full signed range.
    always_comb begin
        step_ext = {{(VEL_W-15){1'b0}}, step};
        if (step == 16'd0) begin
            step_ext = {{VEL_W{1'b0}}, 1'b1};
        end
        cur_ext   = {current[VEL_W-1], current};
        diff      = {target[VEL_W-1], target} - cur_ext;
        diff_mag  = diff[VEL_W] ? $unsigned(-diff) : $unsigned(diff);
        moved     = diff[VEL_W] ? (cur_ext - $signed(step_ext)) : (cur_ext + $signed(step_ext));
        at_target = (diff_mag <= step_ext);
        next      = at_target ? target : moved[VEL_W-1:0];
    end

endmodule

// File: rtl/homing_sequencer.sv
// Homing run sequencer: ramps a seek velocity up, latches the encoder position
// on the index edge, ramps back down, with timeout and abort handling.
module homing_sequencer
    import motor_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int VEL_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    encoder_index,
    input  logic signed [VEL_W-1:0] actual_position,
    input  logic signed [VEL_W-1:0] homing_vel,
    input  logic        [15:0]      accel_step,
    input  logic        [15:0]      timeout_ms,
    output logic signed [VEL_W-1:0] desired_vel,
    output logic signed [VEL_W-1:0] home_offset,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic        [1:0]       fault_code,
    output logic        [2:0]       state
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0]      presc_reg;
    logic                    tick;
    logic [2:0]              idx_pipe_reg;
    logic                    idx_rise_reg;

    hs_state_e               state_reg, state_next;
    logic signed [VEL_W-1:0] vel_reg, vel_next;
    logic signed [VEL_W-1:0] offset_reg, offset_next;
    logic signed [VEL_W-1:0] tgt_reg, tgt_next;
    logic [15:0]             step_reg, step_next;
    logic [15:0]             tmo_lim_reg, tmo_lim_next;
    logic [15:0]             tmo_cnt_reg, tmo_cnt_next;
    logic                    aborted_reg, aborted_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    fault_reg, fault_next;
    logic [1:0]              code_reg, code_next;

    logic signed [VEL_W-1:0] ramp_target;
    logic signed [VEL_W-1:0] ramp_next;
    logic                    ramp_at_target;
    logic                    timeout_hit;
    logic                    zero_vel;

    assign tick        = (presc_reg == PRESC_LAST);
    assign timeout_hit = (tmo_lim_reg != 16'd0) && (tmo_cnt_reg == tmo_lim_reg);
    assign zero_vel    = (state_reg == ST_RAMP_UP) && (tgt_reg == '0);
    assign ramp_target = (state_reg == ST_RAMP_DOWN) ? '0 : tgt_reg;

    vel_ramp #(
        .VEL_W (VEL_W)
    ) u_vel_ramp (
        .current   (vel_reg),
        .target    (ramp_target),
        .step      (step_reg),
        .next      (ramp_next),
        .at_target (ramp_at_target)
    );

    // State and output registers; the async clear also zeroes the velocity command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg    <= '0;
            idx_pipe_reg <= '0;
            idx_rise_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            vel_reg      <= '0;
            offset_reg   <= '0;
            tgt_reg      <= '0;
            step_reg     <= '0;
            tmo_lim_reg  <= '0;
            tmo_cnt_reg  <= '0;
            aborted_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fault_reg    <= 1'b0;
            code_reg     <= FAULT_NONE;
        end else begin
            presc_reg    <= tick ? '0 : presc_reg + 1'b1;
            idx_pipe_reg <= {idx_pipe_reg[1:0], encoder_index};
            idx_rise_reg <= idx_pipe_reg[1] & ~idx_pipe_reg[2];
            state_reg    <= state_next;
            vel_reg      <= vel_next;
            offset_reg   <= offset_next;
            tgt_reg      <= tgt_next;
            step_reg     <= step_next;
            tmo_lim_reg  <= tmo_lim_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            aborted_reg  <= aborted_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            fault_reg    <= fault_next;
            code_reg     <= code_next;
        end
    end

    // Priority within a seek: zero target, then index/abort, then timeout, then ramp.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start && !abort) begin
                    state_next = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP, ST_SEEK: begin
                if (zero_vel) begin
                    state_next = ST_FAULT;
                end else if (idx_rise_reg || abort) begin
                    state_next = ST_RAMP_DOWN;
                end else if (timeout_hit) begin
                    state_next = ST_FAULT;
                end else if (tick && (state_reg == ST_RAMP_UP) && ramp_at_target) begin
                    state_next = ST_SEEK;
                end
            end
            ST_RAMP_DOWN: begin
                if (tick && ramp_at_target) begin
                    state_next = (aborted_reg || abort) ? ST_IDLE : ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        vel_next     = vel_reg;
        offset_next  = offset_reg;
        tgt_next     = tgt_reg;
        step_next    = step_reg;
        tmo_lim_next = tmo_lim_reg;
        tmo_cnt_next = tmo_cnt_reg;
        aborted_next = aborted_reg;
        done_next    = done_reg;
        fault_next   = fault_reg;
        code_next    = code_reg;
        busy_next    = is_busy(state_next);

        if (!is_busy(state_reg) && (state_next == ST_RAMP_UP)) begin
            tgt_next     = homing_vel;
            step_next    = accel_step;
            tmo_lim_next = timeout_ms;
            tmo_cnt_next = '0;
            aborted_next = 1'b0;
            done_next    = 1'b0;
            fault_next   = 1'b0;
            code_next    = FAULT_NONE;
        end
        if (is_busy(state_reg) && abort) begin
            aborted_next = 1'b1;
        end
        if (is_seeking(state_reg) && idx_rise_reg && (state_next == ST_RAMP_DOWN)) begin
            offset_next = actual_position;
        end
        if (tick && is_seeking(state_reg) && is_seeking(state_next)) begin
            vel_next     = ramp_next;
            tmo_cnt_next = tmo_cnt_reg + 16'd1;
        end
        if (tick && (state_reg == ST_RAMP_DOWN)) begin
            vel_next = ramp_next;
        end
        // A fault drops the command straight to zero rather than ramping.
        if ((state_next == ST_FAULT) && (state_reg != ST_FAULT)) begin
            vel_next   = '0;
            fault_next = 1'b1;
            code_next  = zero_vel ? FAULT_ZERO_VEL : FAULT_TIMEOUT;
        end
        if ((state_next == ST_DONE) && (state_reg == ST_RAMP_DOWN)) begin
            done_next = 1'b1;
        end
    end

    assign desired_vel = vel_reg;
    assign home_offset = offset_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign fault       = fault_reg;
    assign fault_code  = code_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_homing_sequencer.sv
// Bench for homing_sequencer: scenario table, hand-timed corner sequences and a
// randomized run, all checked every cycle against a behavioural model.
module tb_homing_sequencer;

    localparam int TD = 10;
    localparam int VW = 32;

    localparam int S_IDLE = 0;
    localparam int S_RU   = 1;
    localparam int S_SEEK = 2;
    localparam int S_RD   = 3;
    localparam int S_DONE = 4;
    localparam int S_FLT  = 5;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 encoder_index = 1'b0;
    logic signed [VW-1:0] actual_position = '0;
    logic signed [VW-1:0] homing_vel = '0;
    logic [15:0]          accel_step = '0;
    logic [15:0]          timeout_ms = '0;
    logic signed [VW-1:0] desired_vel;
    logic signed [VW-1:0] home_offset;
    logic                 busy;
    logic                 done;
    logic                 fault;
    logic [1:0]           fault_code;
    logic [2:0]           state;

    int checks = 0;
    int errors = 0;

    homing_sequencer #(
        .TICK_DIV (TD),
        .VEL_W    (VW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .encoder_index   (encoder_index),
        .actual_position (actual_position),
        .homing_vel      (homing_vel),
        .accel_step      (accel_step),
        .timeout_ms      (timeout_ms),
        .desired_vel     (desired_vel),
        .home_offset     (home_offset),
        .busy            (busy),
        .done            (done),
        .fault           (fault),
        .fault_code      (fault_code),
        .state           (state)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    int       m_state;
    longint   m_vel, m_off, m_tgt;
    int       m_step, m_tmo, m_cnt, m_code, m_edges;
    bit       m_aborted, m_done, m_fault;
    bit [3:0] xh;   // encoder_index samples from the last four edges, newest in bit 0

    task automatic model_reset();
        m_state = S_IDLE; m_vel = 0; m_off = 0; m_tgt = 0;
        m_step = 0; m_tmo = 0; m_cnt = 0; m_code = 0; m_edges = 0;
        m_aborted = 0; m_done = 0; m_fault = 0; xh = '0;
    endtask

    function automatic longint ramp(longint cur, longint tgt, int stp);
        longint d = tgt - cur;
        longint s = (stp == 0) ? 1 : stp;
        longint a = (d < 0) ? -d : d;
        if (a <= s) return tgt;
        return (d > 0) ? cur + s : cur - s;
    endfunction

    task automatic go_fault(input int code);
        m_state = S_FLT; m_vel = 0; m_fault = 1; m_code = code;
    endtask

    task automatic model_step();
        bit tk, ev;
        m_edges++;
        tk = (m_edges % TD) == 0;
        ev = xh[2] & ~xh[3];
        xh = {xh[2:0], encoder_index};
        case (m_state)
            S_IDLE, S_DONE, S_FLT: begin
                if (start && !abort) begin
                    m_tgt = homing_vel; m_step = accel_step; m_tmo = timeout_ms;
                    m_done = 0; m_fault = 0; m_code = 0; m_cnt = 0; m_aborted = 0;
                    m_state = S_RU;
                end
            end
            S_RU, S_SEEK: begin
                if (abort) m_aborted = 1;
                if (m_state == S_RU && m_tgt == 0) go_fault(2);
                else if (ev || abort) begin
                    if (ev) m_off = actual_position;
                    m_state = S_RD;
                end else if (m_tmo != 0 && m_cnt == m_tmo) go_fault(1);
                else if (tk) begin
                    m_cnt++;
                    m_vel = ramp(m_vel, m_tgt, m_step);
                    if (m_state == S_RU && m_vel == m_tgt) m_state = S_SEEK;
                end
            end
            S_RD: begin
                if (abort) m_aborted = 1;
                if (tk) begin
                    m_vel = ramp(m_vel, 0, m_step);
                    if (m_vel == 0) begin
                        if (m_aborted) m_state = S_IDLE;
                        else begin m_state = S_DONE; m_done = 1; end
                    end
                end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [71:0] exp_v, act_v;
        logic [31:0] ev, eo;
        bit          eb;
        ev = m_vel[31:0];
        eo = m_off[31:0];
        eb = (m_state >= S_RU) && (m_state <= S_RD);
        exp_v = {3'(m_state), ev, eo, eb, m_done, m_fault, 2'(m_code)};
        act_v = {state, desired_vel, home_offset, busy, done, fault, fault_code};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model t=%0t got st=%0d vel=%0d off=%0d bdf=%b%b%b code=%0d expected st=%0d vel=%0d off=%0d bdf=%b%b%b code=%0d",
                     $time, state, desired_vel, home_offset, busy, done, fault, fault_code,
                     m_state, m_vel, m_off, eb, m_done, m_fault, m_code);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_step();
        else model_reset();
        #1;
        compare_all();
        actual_position = $urandom;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_vel"}, desired_vel, 0);
        chk({tag, "_offset"}, home_offset, 0);
        chk({tag, "_state"}, state, S_IDLE);
        chk({tag, "_bdf"}, {busy, done, fault}, 0);
        chk({tag, "_code"}, fault_code, 0);
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int hv; int acc; int tmo; int idx_at; int abort_at;
        int exp_first; int exp_peak; int exp_state; int exp_done; int exp_fault; int exp_code;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int n);
        int     cn;
        longint first_v, peak, a;
        bit     seen;
        homing_vel = v.hv; accel_step = 16'(v.acc); timeout_ms = 16'(v.tmo);
        start = 1'b1; cyc(); start = 1'b0;
        first_v = 0; peak = 0; seen = 0; cn = 1;
        while (busy && cn < 8000) begin
            if (v.idx_at != 0 && cn == v.idx_at) encoder_index = 1'b1;
            if (v.idx_at != 0 && cn == v.idx_at + 5) encoder_index = 1'b0;
            abort = (v.abort_at != 0 && cn == v.abort_at);
            cyc();
            cn++;
            a = desired_vel;
            if (!seen && a != 0) begin seen = 1; first_v = a; end
            if (a < 0) a = -a;
            if (a > peak) peak = a;
        end
        abort = 1'b0; encoder_index = 1'b0;
        chk($sformatf("vec%0d_finished", n), busy, 0);
        chk($sformatf("vec%0d_state", n), state, v.exp_state);
        chk($sformatf("vec%0d_done", n), done, v.exp_done);
        chk($sformatf("vec%0d_fault", n), fault, v.exp_fault);
        chk($sformatf("vec%0d_code", n), fault_code, v.exp_code);
        chk($sformatf("vec%0d_first_vel", n), first_v, v.exp_first);
        chk($sformatf("vec%0d_peak_vel", n), peak, v.exp_peak);
        $display("vec %0d hv=%0d acc=%0d tmo=%0d -> state=%0d done=%0d fault=%0d code=%0d first=%0d peak=%0d cycles=%0d",
                 n, v.hv, v.acc, v.tmo, state, done, fault, fault_code, first_v, peak, cn);
    endtask

    initial begin
        int                   s_edge, t_hit, n, starts;
        logic signed [VW-1:0] exp_off;

        vecs[0] = '{1000,  250, 0,  100,  0,  250, 1000, S_DONE, 1, 0, 0};
        vecs[1] = '{1000,   50, 5,    0,  0,   50,  250, S_FLT,  0, 1, 1};
        vecs[2] = '{-300,    0, 0, 3100,  0,   -1,  300, S_DONE, 1, 0, 0};
        vecs[3] = '{1000,  500, 0,    0, 50,  500, 1000, S_IDLE, 0, 0, 0};
        vecs[4] = '{0,     250, 0,    0,  0,    0,    0, S_FLT,  0, 1, 2};
        vecs[5] = '{-1000, 300, 0,   60,  0, -300, 1000, S_DONE, 1, 0, 0};
        vecs[6] = '{1000,  400, 2,    0,  0,  400,  800, S_FLT,  0, 1, 1};

        #2;
        do_reset("reset");
        $display("reset applied: state=%0d vel=%0d", state, desired_vel);

        // start and abort together in IDLE: abort wins
        homing_vel = 1000; accel_step = 16'd250;
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        cyc();
        chk("start_abort_state", state, S_IDLE);
        chk("start_abort_busy", busy, 0);
        $display("start+abort in IDLE: state=%0d busy=%0d", state, busy);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // index and timeout in the same cycle, with an ignored start while busy
        homing_vel = 1000; accel_step = 16'd100; timeout_ms = 16'd2;
        start = 1'b1; cyc(); start = 1'b0;
        s_edge  = m_edges;
        t_hit   = (s_edge / TD + 1) * TD + TD + 1;
        exp_off = '0;
        while (m_edges < t_hit) begin
            encoder_index = (m_edges + 1 >= t_hit - 3);
            start = (m_edges + 1 == s_edge + 2);
            if (start) homing_vel = -77;
            if (m_edges + 1 == t_hit) exp_off = actual_position;
            cyc();
        end
        start = 1'b0; encoder_index = 1'b0;
        chk("tie_state", state, S_RD);
        chk("tie_offset", home_offset, exp_off);
        chk("tie_fault", fault, 0);
        chk("tie_vel", desired_vel, 200);
        n = 0;
        while (busy && n < 500) begin cyc(); n++; end
        chk("tie_done", done, 1);
        $display("index/timeout tie: offset=%0d done=%0d fault=%0d", home_offset, done, fault);

        // asynchronous reset in the middle of a ramp
        homing_vel = 1000; accel_step = 16'd250; timeout_ms = 16'd0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 25; i++) cyc();
        #2;
        do_reset("midrun_reset");
        $display("mid-run async reset: state=%0d vel=%0d", state, desired_vel);

        // randomized traffic against the model
        starts = 0;
        for (int blk = 0; blk < 15; blk++) begin
            if (blk == 7) begin
                #2;
                do_reset("random_reset");
            end
            for (int i = 0; i < 1000; i++) begin
                start = ($urandom_range(0, 39) == 0);
                abort = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 49) == 0) encoder_index = ~encoder_index;
                if (start || $urandom_range(0, 99) == 0) begin
                    homing_vel = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 4000)) - 2000;
                    accel_step = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 600));
                    timeout_ms = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
                end
                if (start) starts++;
                cyc();
            end
            start = 1'b0; abort = 1'b0;
            $display("random block %0d: starts=%0d checks=%0d errors=%0d", blk, starts, checks, errors);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
